game_sequencer: RTL and testbench

- Top-level game-flow controller for the road-fighter datapath.
- Generates the periodic update strobes (upsig, upsig_fast), obstacle drop requests and the alive enable that drive the player, obstacle manager, background, scoreboard and music blocks.
- Runs the IDLE/PLAYING/CRASH/OVER state machine, driven by the start button and the colision flag from the collision manager.
- Tracks remaining lives.

---
 rtl/game_sequencer.sv | 146 ++++++++++++++
 tb/tb_game_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Game-flow controller: prescaled update strobes, obstacle drop requests and the
// IDLE/PLAYING/CRASH/OVER state machine with life tracking.
module game_sequencer #(
    parameter int CNT_W       = 24,
    parameter int SLOW_DIV    = 833333,
    parameter int FAST_DIV    = 416666,
    parameter int DROP_PERIOD = 90,
    parameter int CRASH_TICKS = 120,
    parameter int LIVES       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       colision,
    output logic       upsig,
    output logic       upsig_fast,
    output logic       drop,
    output logic       alive,
    output logic [1:0] lives,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_CRASH = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] SLOW_LAST  = CNT_W'(SLOW_DIV - 1);
    localparam logic [CNT_W-1:0] FAST_LAST  = CNT_W'(FAST_DIV - 1);
    localparam logic [7:0]       DROP_LAST  = 8'(DROP_PERIOD - 1);
    localparam logic [7:0]       CRASH_LAST = 8'(CRASH_TICKS - 1);
    localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

    state_t           state_q, state_d;
    logic [1:0]       lives_q, lives_d;
    logic [CNT_W-1:0] slow_cnt_q, slow_cnt_d;
    logic [CNT_W-1:0] fast_cnt_q, fast_cnt_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic [7:0]       crash_cnt_q, crash_cnt_d;
    logic             start_q;
    logic             upsig_q, upsig_fast_q, drop_q, alive_q;
    logic             upsig_d, upsig_fast_d, drop_d, alive_d;
    logic             slow_tick, fast_tick, start_edge;

    assign slow_tick  = (slow_cnt_q == SLOW_LAST);
    assign fast_tick  = (fast_cnt_q == FAST_LAST);
    assign start_edge = start & ~start_q;

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        slow_cnt_d  = slow_tick ? '0 : slow_cnt_q + CNT_W'(1);
        fast_cnt_d  = fast_tick ? '0 : fast_cnt_q + CNT_W'(1);
        drop_cnt_d  = drop_cnt_q;
        crash_cnt_d = crash_cnt_q;
        drop_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    // New game: resync the prescalers so the first tick is a full period away
                    state_d    = S_PLAY;
                    lives_d    = LIVES_INIT;
                    drop_cnt_d = '0;
                    slow_cnt_d = '0;
                    fast_cnt_d = '0;
                end
            end
            S_PLAY: begin
                if (colision) begin
                    state_d     = S_CRASH;
                    crash_cnt_d = '0;
                    if (lives_q != 2'd0) begin
                        lives_d = lives_q - 2'd1;
                    end
                end else if (slow_tick) begin
                    if (drop_cnt_q == DROP_LAST) begin
                        drop_cnt_d = '0;
                        drop_d     = 1'b1;
                    end else begin
                        drop_cnt_d = drop_cnt_q + 8'd1;
                    end
                end
            end
            S_CRASH: begin
                // Invulnerable here: colision is not looked at until back in PLAYING
                if (slow_tick) begin
                    if (crash_cnt_q == CRASH_LAST) begin
                        state_d = (lives_q == 2'd0) ? S_OVER : S_PLAY;
                    end else begin
                        crash_cnt_d = crash_cnt_q + 8'd1;
                    end
                end
            end
            S_OVER: begin
                lives_d = 2'd0;
                if (start_edge) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A colliding cycle already belongs to the frozen world, so its tick is dropped
    assign upsig_d      = slow_tick & (state_q == S_PLAY) & ~colision;
    assign upsig_fast_d = fast_tick & (state_q == S_PLAY) & ~colision;
    assign alive_d      = (state_d == S_PLAY);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            lives_q      <= 2'd0;
            slow_cnt_q   <= '0;
            fast_cnt_q   <= '0;
            drop_cnt_q   <= '0;
            crash_cnt_q  <= '0;
            start_q      <= 1'b1;
            upsig_q      <= 1'b0;
            upsig_fast_q <= 1'b0;
            drop_q       <= 1'b0;
            alive_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            slow_cnt_q   <= slow_cnt_d;
            fast_cnt_q   <= fast_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            crash_cnt_q  <= crash_cnt_d;
            start_q      <= start;
            upsig_q      <= upsig_d;
            upsig_fast_q <= upsig_fast_d;
            drop_q       <= drop_d;
            alive_q      <= alive_d;
        end
    end

    assign upsig      = upsig_q;
    assign upsig_fast = upsig_fast_q;
    assign drop       = drop_q;
    assign alive      = alive_q;
    assign lives      = lives_q;
    assign state      = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with small dividers so every flow fits in a few dozen clocks.
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, colision;
    logic       upsig, upsig_fast, drop, alive;
    logic [1:0] lives, state;

    int n_checks = 0;
    int n_errors = 0;
    int drops;

    game_sequencer #(
        .CNT_W(24), .SLOW_DIV(4), .FAST_DIV(2),
        .DROP_PERIOD(3), .CRASH_TICKS(2), .LIVES(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .colision(colision),
        .upsig(upsig), .upsig_fast(upsig_fast), .drop(drop), .alive(alive),
        .lives(lives), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".upsig"}, upsig, 0);
        chk({tag, ".fast"},  upsig_fast, 0);
        chk({tag, ".drop"},  drop, 0);
        chk({tag, ".alive"}, alive, 0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b1; colision = 1'b0;
        repeat (3) step();
        chk("rst.state", state, 0);
        chk("rst.lives", lives, 0);
        chk_quiet("rst");

        // Start held through reset must not start a game
        reset = 1'b1;
        repeat (3) step();
        chk("held.state", state, 0);
        chk_quiet("held");

        start = 1'b0; step();
        start = 1'b1; step();
        chk("go.state", state, 1);
        chk("go.lives", lives, 2);
        chk("go.alive", alive, 1);
        chk("go.upsig", upsig, 0);

        // 13 slow ticks: upsig every 4, fast every 2, drop on every 3rd upsig
        drops = 0;
        for (int k = 1; k <= 52; k++) begin
            step();
            chk($sformatf("play%0d.upsig", k), upsig, (k % 4 == 0));
            chk($sformatf("play%0d.fast", k), upsig_fast, (k % 2 == 0));
            chk($sformatf("play%0d.drop", k), drop, (k % 12 == 0));
            chk($sformatf("play%0d.state", k), state, 1);
            if (k <= 48 && drop) drops++;
        end
        chk("drops12", drops, 4);

        // Single-cycle colision; drop counter currently holds 1
        colision = 1'b1; step(); colision = 1'b0;
        chk("hit.state", state, 2);
        chk("hit.lives", lives, 1);
        chk("hit.alive", alive, 0);
        chk("hit.upsig", upsig, 0);
        chk("hit.drop", drop, 0);
        for (int k = 54; k <= 59; k++) begin
            step();
            chk($sformatf("crash%0d.state", k), state, 2);
            chk_quiet($sformatf("crash%0d", k));
        end
        step();
        chk("back.state", state, 1);
        chk("back.alive", alive, 1);
        chk("back.upsig", upsig, 0);
        repeat (4) step();
        chk("kept.upsig", upsig, 1);
        chk("kept.drop", drop, 0);
        repeat (4) step();
        chk("kept2.upsig", upsig, 1);
        chk("kept2.drop", drop, 1);

        // Fresh game, then colision held high through both crashes
        reset = 1'b0; step();
        chk("rst2.state", state, 0);
        reset = 1'b1; start = 1'b0; step();
        start = 1'b1; step();
        chk("go2.state", state, 1);
        colision = 1'b1;
        step();
        chk("hold1.state", state, 2);
        chk("hold1.lives", lives, 1);
        repeat (6) step();
        chk("hold7.state", state, 2);
        step();
        chk("hold8.state", state, 1);
        chk("hold8.alive", alive, 1);
        step();
        chk("hold9.state", state, 2);
        chk("hold9.lives", lives, 0);
        chk("hold9.alive", alive, 0);
        repeat (6) step();
        chk("hold15.state", state, 2);
        step();
        chk("over.state", state, 3);
        chk("over.lives", lives, 0);
        chk_quiet("over");
        colision = 1'b0;
        repeat (2) step();
        chk("over.hold", state, 3);
        start = 1'b0; step();
        start = 1'b1; step();
        chk("over2idle", state, 0);
        start = 1'b0; step();
        start = 1'b1; step();
        chk("regame.state", state, 1);
        chk("regame.lives", lives, 2);

        // colision on the slow-tick cycle: that tick yields neither upsig nor drop
        repeat (3) step();
        chk("pretick.state", state, 1);
        colision = 1'b1; step(); colision = 1'b0;
        chk("simul.state", state, 2);
        chk("simul.upsig", upsig, 0);
        chk("simul.drop", drop, 0);
        chk("simul.lives", lives, 1);

        // Reset in CRASH aborts at once
        reset = 1'b0; step();
        chk("abort.state", state, 0);
        chk("abort.lives", lives, 0);
        chk_quiet("abort");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
